isa_set_slice: RTL and testbench



---
 rtl/isa_pkg.sv | 20 ++
 rtl/isa_set_slice_if.sv | 30 +++
 rtl/isa_slice_merge.sv | 43 ++++
 rtl/isa_set_slice.sv | 175 +++++++++++++++++
 tb/tb_isa_set_slice.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA execution-unit definitions:
// mode encodings and the multi-cycle unit state enum.
package isa_pkg;

  localparam logic [1:0] MODE_KEEP = 2'd0;
  localparam logic [1:0] MODE_ZERO = 2'd1;
  localparam logic [1:0] MODE_SIGN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } isa_state_t;

  function automatic logic mode_valid(input logic [1:0] m);
    return m != 2'd3;
  endfunction

endpackage

// File: rtl/isa_set_slice_if.sv
// Register-file port shared by the ISA units:
// index, read/write strobes, write data and read data.
interface isa_set_slice_if #(
  parameter int XLEN  = 64,
  parameter int REG_W = 4
);

  logic [REG_W-1:0] reg_id;
  logic             reg_re;
  logic [XLEN-1:0]  reg_wd;
  logic             reg_we;
  logic [XLEN-1:0]  reg_out;

  modport master (
    output reg_id,
    output reg_re,
    output reg_wd,
    output reg_we,
    input  reg_out
  );

  modport slave (
    input  reg_id,
    input  reg_re,
    input  reg_wd,
    input  reg_we,
    output reg_out
  );

endinterface

// File: rtl/isa_slice_merge.sv
// Combinational slice merge: places imm at slice pos
// of an XLEN word, keeping, zeroing or sign-filling.
import isa_pkg::*;

module isa_slice_merge #(
  parameter int XLEN  = 64,
  parameter int IMM_W = 16,
  parameter int POS_W = $clog2(XLEN/IMM_W)
) (
  input  logic [XLEN-1:0]  old,
  input  logic [IMM_W-1:0] imm,
  input  logic [POS_W-1:0] pos,
  input  logic [1:0]       mode,
  output logic [XLEN-1:0]  merged
);

  localparam int SH_W = $clog2(XLEN) + 1;

  logic [SH_W-1:0] sh;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] field;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] above;

  assign sh    = SH_W'(pos) * SH_W'(IMM_W);
  assign ext   = {{(XLEN-IMM_W){1'b0}}, imm};
  assign field = ext << sh;
  assign mask  = {{(XLEN-IMM_W){1'b0}}, {IMM_W{1'b1}}} << sh;
  // top slice shifts by XLEN, leaving nothing above
  assign above = {XLEN{1'b1}} << (sh + SH_W'(IMM_W));

  // select the merge rule for the requested mode
  always_comb begin
    merged = '0;
    case (mode)
      MODE_KEEP: merged = (old & ~mask) | field;
      MODE_ZERO: merged = field;
      MODE_SIGN: merged = field | (imm[IMM_W-1] ? above : '0);
      default:   merged = '0;
    endcase
  end

endmodule

// File: rtl/isa_set_slice.sv
// Immediate-to-slice set unit: writes imm into a
// runtime-selected slice of a register via the regfile port.
import isa_pkg::*;

module isa_set_slice #(
  parameter int XLEN  = 64,
  parameter int IMM_W = 16,
  parameter int REG_W = 4,
  parameter int POS_W = $clog2(XLEN/IMM_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enabled,
  input  logic [REG_W-1:0] r0,
  input  logic [IMM_W-1:0] imm,
  input  logic [POS_W-1:0] pos,
  input  logic [1:0]       mode,
  isa_set_slice_if.master  rf,
  output logic             finished,
  output logic             error
);

  localparam int SLICES = XLEN / IMM_W;

  if (XLEN % IMM_W != 0) begin : g_bad_div
    $error("XLEN must be a multiple of IMM_W");
  end
  if (SLICES < 2 || (SLICES & (SLICES - 1)) != 0) begin : g_bad_pow2
    $error("XLEN/IMM_W must be a power of two >= 2");
  end

  isa_state_t       state_q, state_d;
  logic [REG_W-1:0] r0_q, r0_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       mode_q, mode_d;
  logic             re_q, re_d;
  logic             we_q, we_d;
  logic [XLEN-1:0]  wd_q, wd_d;
  logic             fin_q, fin_d;
  logic             err_q, err_d;

  logic             idle;
  logic [IMM_W-1:0] m_imm;
  logic [POS_W-1:0] m_pos;
  logic [1:0]       m_mode;
  logic [XLEN-1:0]  merged;

  // in IDLE the live inputs feed the merge so ZERO/SIGN write next edge
  assign idle   = (state_q == ST_IDLE);
  assign m_imm  = idle ? imm  : imm_q;
  assign m_pos  = idle ? pos  : pos_q;
  assign m_mode = idle ? mode : mode_q;

  isa_slice_merge #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W),
    .POS_W (POS_W)
  ) u_merge (
    .old    (rf.reg_out),
    .imm    (m_imm),
    .pos    (m_pos),
    .mode   (m_mode),
    .merged (merged)
  );

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r0_q    <= '0;
      imm_q   <= '0;
      pos_q   <= '0;
      mode_q  <= MODE_KEEP;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      imm_q   <= imm_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    imm_d   = imm_q;
    pos_d   = pos_q;
    mode_d  = mode_q;
    re_d    = re_q;
    we_d    = we_q;
    wd_d    = wd_q;
    fin_d   = fin_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enabled) begin
          r0_d   = r0;
          imm_d  = imm;
          pos_d  = pos;
          mode_d = mode;
          unique case (1'b1)
            (mode == MODE_KEEP): begin
              re_d    = 1'b1;
              state_d = ST_READ;
            end
            (mode == MODE_ZERO),
            (mode == MODE_SIGN): begin
              wd_d    = merged;
              we_d    = 1'b1;
              state_d = ST_WRITE;
            end
            default: begin
              fin_d   = 1'b1;
              err_d   = !mode_valid(mode);
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_READ: begin
        re_d = 1'b0;
        if (!enabled) begin
          we_d    = 1'b0;
          fin_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          wd_d    = merged;
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we_d = 1'b0;
        re_d = 1'b0;
        if (!enabled) begin
          fin_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          fin_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enabled) begin
          fin_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf.reg_id = r0_q;
  assign rf.reg_re = re_q;
  assign rf.reg_we = we_q;
  assign rf.reg_wd = wd_q;
  assign finished  = fin_q;
  assign error     = err_q;

endmodule

// File: tb/tb_isa_set_slice.sv
// Bench for isa_set_slice: table vectors, random ops vs
// a bitwise reference model, abort/reset sequences.
module tb_isa_set_slice;
  import isa_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a  = 1'b0;
  logic        en_b  = 1'b0;
  logic [3:0]  r0    = '0;
  logic [15:0] imm   = '0;
  logic [1:0]  pos   = '0;
  logic [1:0]  mode  = '0;
  logic [63:0] old_a = '0;
  logic [31:0] old_b = '0;
  bit          sel   = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic fin_a, err_a, fin_b, err_b;

  always #5 clk = ~clk;

  isa_set_slice_if #(.XLEN(64), .REG_W(4)) ia();
  isa_set_slice_if #(.XLEN(32), .REG_W(4)) ib();

  assign ia.reg_out = old_a;
  assign ib.reg_out = old_b;

  isa_set_slice #(.XLEN(64), .IMM_W(16), .REG_W(4)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .enabled  (en_a),
    .r0       (r0),
    .imm      (imm),
    .pos      (pos),
    .mode     (mode),
    .rf       (ia.master),
    .finished (fin_a),
    .error    (err_a)
  );

  isa_set_slice #(.XLEN(32), .IMM_W(8), .REG_W(4)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .enabled  (en_b),
    .r0       (r0),
    .imm      (imm[7:0]),
    .pos      (pos),
    .mode     (mode),
    .rf       (ib.master),
    .finished (fin_b),
    .error    (err_b)
  );

  logic        s_re, s_we, s_fin, s_err;
  logic [63:0] s_wd;
  logic [3:0]  s_id;

  always_comb begin
    if (sel) begin
      s_re  = ib.reg_re;
      s_we  = ib.reg_we;
      s_fin = fin_b;
      s_err = err_b;
      s_wd  = {32'b0, ib.reg_wd};
      s_id  = ib.reg_id;
    end else begin
      s_re  = ia.reg_re;
      s_we  = ia.reg_we;
      s_fin = fin_a;
      s_err = err_a;
      s_wd  = ia.reg_wd;
      s_id  = ia.reg_id;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // bit-by-bit statement of the slice rules
  function automatic logic [63:0] model(input int xlen, input int immw,
      input logic [1:0] md, input logic [15:0] im, input int p,
      input logic [63:0] old);
    logic [63:0] r;
    int lo;
    r  = '0;
    lo = p * immw;
    for (int i = 0; i < xlen; i++) begin
      if (i < lo)
        r[i] = (md == 2'd0) ? old[i] : 1'b0;
      else if (i < lo + immw)
        r[i] = im[i-lo];
      else if (md == 2'd0)
        r[i] = old[i];
      else if (md == 2'd1)
        r[i] = 1'b0;
      else
        r[i] = im[immw-1];
    end
    return r;
  endfunction

  task automatic set_en(input logic v);
    if (sel) en_b = v;
    else en_a = v;
  endtask

  task automatic run_op(input bit s, input logic [1:0] md,
      input logic [3:0] r, input logic [15:0] im, input logic [1:0] p,
      input logic [63:0] old, input logic [63:0] exp_wd,
      input string tag);
    int re_n, re_c, we_n, we_c, fin_c, both;
    logic [63:0] wd;
    logic [3:0]  id;
    logic        err;
    bit          kp, rsv;
    re_n = 0; re_c = 0; we_n = 0; we_c = 0; fin_c = 0; both = 0;
    wd = '0; id = '0; err = 1'b0;
    kp  = (md == 2'd0);
    rsv = (md == 2'd3);
    sel = s;
    r0 = r; imm = im; pos = p; mode = md;
    if (s) old_b = old[31:0];
    else old_a = old;
    set_en(1'b1);
    for (int c = 1; c <= 8 && fin_c == 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        r0   = 4'($urandom);
        imm  = 16'($urandom);
        pos  = 2'($urandom);
        mode = 2'($urandom);
      end
      if (s_re && s_we) both++;
      if (s_re) begin re_n++; re_c = c; end
      if (s_we) begin we_n++; we_c = c; wd = s_wd; id = s_id; end
      if (s_fin) begin fin_c = c; err = s_err; end
    end
    chk({tag, ".re_count"}, 64'(re_n), kp ? 64'd1 : 64'd0);
    chk({tag, ".re_cycle"}, 64'(re_c), kp ? 64'd1 : 64'd0);
    chk({tag, ".we_count"}, 64'(we_n), rsv ? 64'd0 : 64'd1);
    chk({tag, ".we_cycle"}, 64'(we_c),
        rsv ? 64'd0 : (kp ? 64'd2 : 64'd1));
    chk({tag, ".fin_cycle"}, 64'(fin_c),
        rsv ? 64'd1 : (kp ? 64'd3 : 64'd2));
    chk({tag, ".error"}, 64'(err), 64'(rsv));
    chk({tag, ".re_we_overlap"}, 64'(both), 64'd0);
    if (!rsv) begin
      chk({tag, ".wd"}, wd, exp_wd);
      chk({tag, ".reg_id"}, 64'(id), 64'(r));
    end
    set_en(1'b0);
    @(posedge clk);
    #1;
    chk({tag, ".clear"}, 64'({s_fin, s_err}), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [3:0]  r;
    logic [15:0] im;
    logic [1:0]  p;
    logic [63:0] old;
    logic [63:0] wd;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int we_seen;
    logic [1:0]  md;
    logic [15:0] im;
    logic [1:0]  p;
    logic [63:0] old;
    bit          s;

    tbl[0] = '{2'd0, 4'd3, 16'hBEEF, 2'd2, 64'h1111_2222_3333_4444,
               64'h1111_BEEF_3333_4444};
    tbl[1] = '{2'd1, 4'd9, 16'h00AB, 2'd3, 64'hDEAD_BEEF_CAFE_F00D,
               64'h00AB_0000_0000_0000};
    tbl[2] = '{2'd2, 4'd1, 16'h8001, 2'd1, 64'h0123_4567_89AB_CDEF,
               64'hFFFF_FFFF_8001_0000};
    tbl[3] = '{2'd2, 4'd2, 16'h7FFF, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_7FFF_0000};
    tbl[4] = '{2'd2, 4'd4, 16'h8000, 2'd3, 64'h0,
               64'h8000_0000_0000_0000};
    tbl[5] = '{2'd0, 4'd15, 16'h0000, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_0000};
    tbl[6] = '{2'd3, 4'd6, 16'h1234, 2'd0, 64'h0, 64'h0};

    #12;
    chk("reset.re", 64'(ia.reg_re), 64'd0);
    chk("reset.we", 64'(ia.reg_we), 64'd0);
    chk("reset.fin_err", 64'({fin_a, err_a}), 64'd0);
    chk("reset.wd", ia.reg_wd, 64'd0);
    chk("reset.id", 64'(ia.reg_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(1'b0, tbl[i].md, tbl[i].r, tbl[i].im, tbl[i].p,
             tbl[i].old, tbl[i].wd, $sformatf("vec%0d", i));

    // KEEP aborted while in READ
    sel = 1'b0;
    r0 = 4'd8; imm = 16'h5555; pos = 2'd1; mode = MODE_KEEP;
    old_a = 64'hAAAA_AAAA_AAAA_AAAA;
    en_a = 1'b1;
    @(posedge clk); #1;
    chk("abort_rd.re", 64'(s_re), 64'd1);
    en_a = 1'b0;
    @(posedge clk); #1;
    chk("abort_rd.outs", 64'({s_re, s_we, s_fin, s_err}), 64'd0);
    we_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (s_we || s_re || s_fin) we_seen++;
    end
    chk("abort_rd.quiet", 64'(we_seen), 64'd0);
    run_op(1'b0, MODE_KEEP, 4'd8, 16'h5555, 2'd1,
           64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_5555_AAAA, "restart");

    // ZERO aborted while in WRITE: write already issued
    r0 = 4'd2; imm = 16'h0F0F; pos = 2'd0; mode = MODE_ZERO;
    en_a = 1'b1;
    @(posedge clk); #1;
    chk("abort_wr.we", 64'(s_we), 64'd1);
    chk("abort_wr.wd", s_wd, 64'h0000_0000_0000_0F0F);
    en_a = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr.outs", 64'({s_re, s_we, s_fin, s_err}), 64'd0);

    // async reset while in WRITE
    r0 = 4'd7; imm = 16'h1234; pos = 2'd1; mode = MODE_ZERO;
    en_a = 1'b1;
    @(posedge clk); #1;
    chk("rst_wr.we", 64'(s_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wr.outs", 64'({s_re, s_we, s_fin, s_err}), 64'd0);
    chk("rst_wr.wd", s_wd, 64'd0);
    chk("rst_wr.id", 64'(s_id), 64'd0);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_wr.idle", 64'({s_re, s_we, s_fin, s_err}), 64'd0);

    // narrow configuration, inputs scrambled after start
    run_op(1'b1, MODE_KEEP, 4'd5, 16'h005A, 2'd3,
           64'h0000_0000_FFFF_FFFF, 64'h0000_0000_5AFF_FFFF, "x32_keep");

    for (int i = 0; i < 40; i++) begin
      s   = 1'($urandom);
      md  = 2'($urandom_range(0, 3));
      im  = 16'($urandom);
      p   = 2'($urandom);
      old = {$urandom, $urandom};
      run_op(s, md, 4'($urandom), im, p, old,
             s ? model(32, 8, md, im, int'(p), old)
               : model(64, 16, md, im, int'(p), old),
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
